// File: rtl/cpu_mem_responder.sv
// Fixed-latency, single-outstanding memory responder for the RV32I multicycle core.
// A transaction commits on the edge entering RESP. The array is split into four byte lanes.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // BUSY occupies LATENCY-1 cycles, so the counter starts at LATENCY-2
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    accept, commit;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              be_reg;
  logic                    read_reg, write_reg, err_reg;
  logic                    req, in_err, use_in;
  logic [ADDR_WIDTH-1:0]   cmt_addr;
  logic [31:0]             cmt_wdata;
  logic [3:0]              cmt_be;
  logic                    cmt_read, cmt_write, cmt_err;
  logic                    wr_commit, rd_load;
  logic [1:0]              unused_addr_bits;

  assign unused_addr_bits = mem_address[1:0];
  assign req    = mem_read | mem_write;
  assign in_err = (mem_read & mem_write) | (|mem_address[31:ADDR_WIDTH+2]);

  // Commit from IDLE only happens with LATENCY==1, before the latches hold the request
  assign use_in    = (state_reg == IDLE);
  assign cmt_addr  = use_in ? mem_address[ADDR_WIDTH+1:2] : addr_reg;
  assign cmt_wdata = use_in ? mem_wdata       : wdata_reg;
  assign cmt_be    = use_in ? mem_byte_enable : be_reg;
  assign cmt_read  = use_in ? mem_read        : read_reg;
  assign cmt_write = use_in ? mem_write       : write_reg;
  assign cmt_err   = use_in ? in_err          : err_reg;
  assign wr_commit = commit & cmt_write & ~cmt_err;
  assign rd_load   = commit & (cmt_read | cmt_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          cnt_next = CNT_INIT;
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp = (state_reg == RESP);
    mem_err  = (state_reg == RESP) & err_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      addr_reg  <= mem_address[ADDR_WIDTH+1:2];
      wdata_reg <= mem_wdata;
      be_reg    <= mem_byte_enable;
      read_reg  <= mem_read;
      write_reg <= mem_write;
      err_reg   <= in_err;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (wr_commit && cmt_be[gi])
          lane_mem[cmt_addr] <= cmt_wdata[8*gi +: 8];
      end

      // Illegal transactions return zero data instead of the array contents
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          lane_q <= 8'd0;
        else if (rd_load)
          lane_q <= cmt_err ? 8'd0 : lane_mem[cmt_addr];
      end

      assign mem_rdata[8*gi +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: LATENCY 2 main instance plus LATENCY 1 and 15 instances.
module tb_cpu_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd [3];
  logic        wr [3];
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [3:0]  be [3];
  logic [31:0] rdata_o [3];
  logic        resp_o [3];
  logic        err_o [3];

  int checks = 0;
  int fails  = 0;

  cpu_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .mem_address(addr[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_wdata(wd[0]), .mem_rdata(rdata_o[0]),
    .mem_resp(resp_o[0]), .mem_err(err_o[0]));

  cpu_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_address(addr[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_wdata(wd[1]), .mem_rdata(rdata_o[1]),
    .mem_resp(resp_o[1]), .mem_err(err_o[1]));

  cpu_mem_responder #(.ADDR_WIDTH(8), .LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .mem_address(addr[2]), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_byte_enable(be[2]), .mem_wdata(wd[2]), .mem_rdata(rdata_o[2]),
    .mem_resp(resp_o[2]), .mem_err(err_o[2]));

  // Issue one request on instance k and wait (bounded) for mem_resp.
  // lat counts cycles from the request cycle to the response cycle; tail is mem_resp one cycle later.
  task automatic txn(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d, input bit perturb,
                     output logic [31:0] q, output logic e, output int lat, output logic tail);
    @(negedge clk);
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (perturb) begin
        rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'hFFFF_FFFC; be[k] = 4'hF; wd[k] = 32'hA5A5_A5A5;
      end
    end while (!resp_o[k] && lat < 40);
    q = rdata_o[k];
    e = err_o[k];
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(negedge clk);
    tail = resp_o[k];
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (resp_o[k] !== 1'b0) begin fails++; $display("FAIL reset_resp[%0d]: got %b expected 0", k, resp_o[k]); end
      checks++; if (err_o[k] !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err_o[k]); end
      checks++; if (rdata_o[k] !== 32'h0) begin fails++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, rdata_o[k]); end
    end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_write_read();
    logic [31:0] q; logic e, tail; int lat;
    txn(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, q, e, lat, tail);
    $display("write 0x10 lat=%0d err=%b", lat, e);
    checks++; if (lat != 2) begin fails++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL wr_err: got %b expected 0", e); end
    checks++; if (tail !== 1'b0) begin fails++; $display("FAIL wr_resp_width: got %b expected 0", tail); end
    txn(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x10 lat=%0d data=%h err=%b", lat, q, e);
    checks++; if (lat != 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++; if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", q); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL rd_err: got %b expected 0", e); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] q; logic e, tail; int lat;
    txn(0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h1122_3344, 1'b0, q, e, lat, tail);
    txn(0, 1'b0, 1'b1, 32'h42, 4'b0100, 32'h00AB_0000, 1'b1, q, e, lat, tail);
    $display("sb 0x42 lat=%0d err=%b", lat, e);
    checks++; if (lat != 2) begin fails++; $display("FAIL sb_latency: got %0d expected 2", lat); end
    txn(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x40 data=%h", q);
    checks++; if (q !== 32'h11AB_3344) begin fails++; $display("FAIL lane_merge: got %h expected 11ab3344", q); end
    txn(0, 1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF, 1'b0, q, e, lat, tail);
    $display("write be=0 lat=%0d err=%b", lat, e);
    checks++; if (lat != 2 || e !== 1'b0) begin fails++; $display("FAIL be_zero_resp: got lat %0d err %b expected 2/0", lat, e); end
    txn(0, 1'b1, 1'b0, 32'h43, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x43 data=%h", q);
    checks++; if (q !== 32'h11AB_3344) begin fails++; $display("FAIL lane_unaligned: got %h expected 11ab3344", q); end
  endtask

  task automatic test_illegal();
    logic [31:0] q; logic e, tail; int lat;
    txn(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h1234_5678, 1'b0, q, e, lat, tail);
    txn(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, q, e, lat, tail);
    $display("rd+wr 0x10 err=%b data=%h", e, q);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL both_err: got %b expected 1", e); end
    checks++; if (q !== 32'h0) begin fails++; $display("FAIL both_rdata: got %h expected 0", q); end
    checks++; if (lat != 2) begin fails++; $display("FAIL both_latency: got %0d expected 2", lat); end
    txn(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    txn(0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x400 err=%b data=%h", e, q);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL oor_rd_err: got %b expected 1", e); end
    checks++; if (q !== 32'h0) begin fails++; $display("FAIL oor_rd_rdata: got %h expected 0", q); end
    txn(0, 1'b0, 1'b1, 32'h400, 4'hF, 32'hCAFE_F00D, 1'b0, q, e, lat, tail);
    $display("write 0x400 err=%b", e);
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL oor_wr_err: got %b expected 1", e); end
    txn(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x0 data=%h err=%b", q, e);
    checks++; if (q !== 32'h1234_5678) begin fails++; $display("FAIL oor_no_alias: got %h expected 12345678", q); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL legal_after_err: got %b expected 0", e); end
    txn(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    checks++; if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL both_no_write: got %h expected deadbeef", q); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] mask;
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      mask[i-1] = resp_o[0];
    end
    rd[0] = 1'b0;
    $display("held read resp mask=%b data=%h", mask, rdata_o[0]);
    checks++; if (mask !== 9'b010010010) begin fails++; $display("FAIL held_resp_mask: got %b expected 010010010", mask); end
    checks++; if (rdata_o[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL held_rdata: got %h expected deadbeef", rdata_o[0]); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] q; logic e, tail; int lat;
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 32'h10;
    @(negedge clk);
    @(negedge clk);
    checks++; if (resp_o[0] !== 1'b1) begin fails++; $display("FAIL pre_reset_resp: got %b expected 1", resp_o[0]); end
    rst = 1'b0; rd[0] = 1'b0;
    #1;
    $display("reset in RESP resp=%b err=%b data=%h", resp_o[0], err_o[0], rdata_o[0]);
    checks++; if (resp_o[0] !== 1'b0) begin fails++; $display("FAIL async_resp_drop: got %b expected 0", resp_o[0]); end
    checks++; if (rdata_o[0] !== 32'h0) begin fails++; $display("FAIL async_rdata_clear: got %h expected 0", rdata_o[0]); end
    @(negedge clk);
    rst = 1'b1;
    txn(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, 1'b0, q, e, lat, tail);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'hF; wd[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0; wr[0] = 1'b0;
    #1;
    checks++; if (resp_o[0] !== 1'b0) begin fails++; $display("FAIL busy_reset_resp: got %b expected 0", resp_o[0]); end
    @(negedge clk);
    checks++; if (resp_o[0] !== 1'b0) begin fails++; $display("FAIL busy_reset_no_pulse: got %b expected 0", resp_o[0]); end
    rst = 1'b1;
    txn(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("read 0x20 after reset data=%h lat=%0d", q, lat);
    checks++; if (q !== 32'h0) begin fails++; $display("FAIL write_discarded: got %h expected 0", q); end
    checks++; if (lat != 2) begin fails++; $display("FAIL post_reset_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_latency_variant(input int k, input int exp_lat);
    logic [31:0] q; logic e, tail; int lat;
    txn(k, 1'b0, 1'b1, 32'h100, 4'hF, 32'h0000_0013, 1'b0, q, e, lat, tail);
    $display("L%0d store lat=%0d", exp_lat, lat);
    checks++; if (lat != exp_lat) begin fails++; $display("FAIL L%0d_store_latency: got %0d expected %0d", exp_lat, lat, exp_lat); end
    checks++; if (tail !== 1'b0) begin fails++; $display("FAIL L%0d_resp_width: got %b expected 0", exp_lat, tail); end
    txn(k, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("L%0d fetch data=%h lat=%0d", exp_lat, q, lat);
    checks++; if (q !== 32'h0000_0013 || lat != exp_lat) begin fails++; $display("FAIL L%0d_fetch: got %h/%0d expected 00000013/%0d", exp_lat, q, lat, exp_lat); end
    txn(k, 1'b0, 1'b1, 32'h101, 4'b0010, 32'h0000_5A00, 1'b1, q, e, lat, tail);
    checks++; if (e !== 1'b0 || lat != exp_lat) begin fails++; $display("FAIL L%0d_sb: got err %b lat %0d expected 0/%0d", exp_lat, e, lat, exp_lat); end
    txn(k, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0, q, e, lat, tail);
    $display("L%0d load data=%h", exp_lat, q);
    checks++; if (q !== 32'h0000_5A13) begin fails++; $display("FAIL L%0d_load: got %h expected 00005a13", exp_lat, q); end
    txn(k, 1'b1, 1'b1, 32'h104, 4'hF, 32'h0, 1'b0, q, e, lat, tail);
    checks++; if (e !== 1'b1 || q !== 32'h0) begin fails++; $display("FAIL L%0d_illegal: got err %b data %h expected 1/0", exp_lat, e, q); end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0; be[k] = 4'h0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_latency_variant(1, 1);
    test_latency_variant(2, 15);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the multicycle RV32I core's single-port memory interface (mem_read/mem_write/mem_byte_enable/mem_resp). Serves one word-wide transaction at a time from an internal word-addressed array, with a parameterised fixed response latency. Sits opposite the CPU control/datapath as the bench and early-integration memory, ahead of the cache that will replace it.

## Interface
- ADDR_WIDTH, 8: word-index bits; array holds 2**ADDR_WIDTH 32-bit words; legal range 2..20
- LATENCY, 2: cycles from request acceptance to mem_resp; legal range 1..15
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous assert, active-low (0 = reset)
- mem_address  input  32  byte address; word index = mem_address[ADDR_WIDTH+1:2]; bits [1:0] ignored
- mem_read  input  1  read request; held until mem_resp seen
- mem_write  input  1  write request; held until mem_resp seen
- mem_byte_enable  input  4  per-byte write enable, bit i -> byte lane i (bits [8i+7:8i])
- mem_wdata  input  32  write data, already lane-aligned by requester
- mem_rdata  output  32  read data; valid in mem_resp cycle of a read, held until next read completes
- mem_resp  output  1  single-cycle completion pulse
- mem_err  output  1  high only with mem_resp when the completed transaction was illegal

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if mem_read or mem_write sampled high -> latch address, wdata, byte_enable, op; go BUSY (or RESP directly when LATENCY==1). Otherwise stay.
- BUSY: down-counter (4 bits) counts remaining wait cycles; on terminal count go RESP.
- RESP: mem_resp=1 for this cycle only; unconditional -> IDLE. Requests visible during RESP are ignored (not accepted).
- Transaction commits on the edge entering RESP: write updates only enabled byte lanes of latched word; read captures full word into mem_rdata (byte_enable ignored for reads).
- Illegal transaction, flagged with mem_err=1 in RESP cycle, array untouched, mem_rdata driven 0:
  - mem_read and mem_write both high at acceptance;
  - out of range: mem_address[31:ADDR_WIDTH+2] nonzero.
- Write with byte_enable 4'b0000: legal, no array change, normal mem_resp.
- Inputs changed or request dropped after acceptance: latched values used; transaction completes normally.
- Requester must drop its request in the cycle after mem_resp; a request still high in the following IDLE cycle is a new transaction.
- Array contents are not reset and power up undefined (X in simulation).

## Timing
- Request first high in cycle t (FSM in IDLE) -> mem_resp high in exactly cycle t+LATENCY, width 1 cycle.
- Minimum back-to-back spacing: next acceptance no earlier than cycle t+LATENCY+1; throughput one transaction per LATENCY+1 cycles.
- Write data readable by a read accepted at or after cycle t+LATENCY+1.
- Reset values: mem_resp=0, mem_err=0, mem_rdata=0, state IDLE, counter 0.
- rst low mid-transaction: immediately IDLE, mem_resp/mem_err drop in same cycle (asynchronous), pending write discarded, array otherwise unchanged; first edge after rst rises may accept a request.
- No combinational path from any input to any output.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x00000010 with be 4'b1111, cycle t -> mem_resp only in t+2; read 0x10 -> mem_rdata=0xDEADBEEF with mem_resp, mem_err=0.
- Byte lanes: word 0x40 = 0x11223344; sb-style write wdata 0x00AB0000 be 4'b0100 to 0x42 -> read 0x40 = 0x11AB3344; read 0x43 returns same word.
- Illegal: mem_read and mem_write both high, then address 0x00000400 with ADDR_WIDTH=8 -> each gets one mem_resp with mem_err=1, mem_rdata=0, no array change (read-back confirms).
- Held request: keep mem_read high through RESP cycle -> exactly one mem_resp per LATENCY+1 cycles, no response during RESP-to-IDLE transition.
- Reset mid-op: accept write to 0x20 (prior 0x0), assert rst in BUSY -> mem_resp never pulses, outputs 0 at once; after release read 0x20 -> 0x00000000.
- LATENCY=1 and LATENCY=15 builds: mem_resp in cycles t+1 and t+15 respectively, running a CPU-style fetch/load/store sequence.
